// File: rtl/ex_mem_pipe_pkg.sv
// rtl/ex_mem_pipe_pkg.sv - shared core package: widths, skid state encoding, mem_size codes
package ex_mem_pipe_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int RA_W_DEF   = 5;
    localparam int SIZE_W_DEF = 3;

    // Occupancy of a two-entry skid stage.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    // mem_size codes; bit 2 marks the zero-extending (unsigned) load variants.
    localparam logic [2:0] MEM_SIZE_B  = 3'b000;
    localparam logic [2:0] MEM_SIZE_H  = 3'b001;
    localparam logic [2:0] MEM_SIZE_W  = 3'b010;
    localparam logic [2:0] MEM_SIZE_BU = 3'b100;
    localparam logic [2:0] MEM_SIZE_HU = 3'b101;

endpackage

// File: rtl/ex_mem_pipe_if.sv
// rtl/ex_mem_pipe_if.sv - EX->MEM stage bus: flush, input handshake/payload, output handshake/payload
//
// slave  : the pipeline stage (receives EX side, drives MEM side)
// master : the surrounding pipeline (drives EX side, receives MEM side)
interface ex_mem_pipe_if
    import ex_mem_pipe_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int RA_W   = RA_W_DEF,
    parameter int SIZE_W = SIZE_W_DEF
);
    logic              flush_i;

    logic              in_valid_i;
    logic              in_ready_o;
    logic [RA_W-1:0]   rd_addr_i;
    logic [XLEN-1:0]   rd_data_i;
    logic              rd_wen_i;
    logic [XLEN-1:0]   mem_addr_i;
    logic [XLEN-1:0]   mem_data_i;
    logic [SIZE_W-1:0] mem_size_i;
    logic              mem_we_i;
    logic              mem_re_i;

    logic              out_valid_o;
    logic              out_ready_i;
    logic [RA_W-1:0]   rd_addr_o;
    logic [XLEN-1:0]   rd_data_o;
    logic              rd_wen_o;
    logic [XLEN-1:0]   mem_addr_o;
    logic [XLEN-1:0]   mem_data_o;
    logic [SIZE_W-1:0] mem_size_o;
    logic              mem_we_o;
    logic              mem_re_o;

    modport slave (
        input  flush_i,
        input  in_valid_i, rd_addr_i, rd_data_i, rd_wen_i,
        input  mem_addr_i, mem_data_i, mem_size_i, mem_we_i, mem_re_i,
        output in_ready_o,
        output out_valid_o, rd_addr_o, rd_data_o, rd_wen_o,
        output mem_addr_o, mem_data_o, mem_size_o, mem_we_o, mem_re_o,
        input  out_ready_i
    );

    modport master (
        output flush_i,
        output in_valid_i, rd_addr_i, rd_data_i, rd_wen_i,
        output mem_addr_i, mem_data_i, mem_size_i, mem_we_i, mem_re_i,
        input  in_ready_o,
        input  out_valid_o, rd_addr_o, rd_data_o, rd_wen_o,
        input  mem_addr_o, mem_data_o, mem_size_o, mem_we_o, mem_re_o,
        output out_ready_i
    );

endinterface

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - generic two-entry skid register with valid/ready/flush
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                drop held entries and any same-cycle input
//   in_valid/in_ready    upstream handshake (in_ready is a flop)
//   in_data[W]           upstream payload
//   out_valid/out_ready  downstream handshake (out_valid is a flop)
//   out_data[W]          downstream payload, straight from the main register
module pipe_skid_reg
    import ex_mem_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         xfer_in;
    logic         xfer_out;

    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = out_valid & out_ready;
    assign out_data = main_q;

    // Main is zeroed whenever the stage empties, so an idle stage presents an
    // all-zero payload (no write/load/store enables on bubbles).
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (xfer_in) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end
            end
            ST_ONE: begin
                if (xfer_in && xfer_out) begin
                    main_d = in_data;
                end else if (xfer_in) begin
                    state_d = ST_TWO;
                    skid_d  = in_data;
                end else if (xfer_out) begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only the drain case exists.
                if (xfer_out) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_d  = '0;
            end
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
        end
    end

    // Handshake outputs are registered from the next state so that in_ready
    // has no combinational path from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            in_ready  <= (state_d != ST_TWO);
            out_valid <= (state_d != ST_EMPTY);
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX/MEM pipeline stage built on a two-entry skid register
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    ex_mem_pipe_if.slave: flush_i, in_valid_i/in_ready_o with writeback
//          (rd_*) and memory (mem_*) payload in; out_valid_o/out_ready_i with
//          the registered payload out
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int RA_W   = RA_W_DEF,
    parameter int SIZE_W = SIZE_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    ex_mem_pipe_if.slave   bus
);

    localparam int PW = RA_W + XLEN + 1 + XLEN + XLEN + SIZE_W + 1 + 1;

    logic [PW-1:0] in_data;
    logic [PW-1:0] out_data;

    assign in_data = {bus.rd_addr_i, bus.rd_data_i, bus.rd_wen_i,
                      bus.mem_addr_i, bus.mem_data_i, bus.mem_size_i,
                      bus.mem_we_i, bus.mem_re_i};

    pipe_skid_reg #(
        .W (PW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush_i),
        .in_valid  (bus.in_valid_i),
        .in_ready  (bus.in_ready_o),
        .in_data   (in_data),
        .out_valid (bus.out_valid_o),
        .out_ready (bus.out_ready_i),
        .out_data  (out_data)
    );

    assign {bus.rd_addr_o, bus.rd_data_o, bus.rd_wen_o,
            bus.mem_addr_o, bus.mem_data_o, bus.mem_size_o,
            bus.mem_we_o, bus.mem_re_o} = out_data;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb/tb_ex_mem_pipe.sv - scoreboard testbench for ex_mem_pipe
module tb_ex_mem_pipe;
    import ex_mem_pipe_pkg::*;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic        rd_wen;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
        logic [2:0]  mem_size;
        logic        mem_we;
        logic        mem_re;
    } pl_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    pl_t  exp_q[$];

    ex_mem_pipe_if bus ();

    ex_mem_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pl_t mk(input logic [4:0] ra, input logic [31:0] rdat, input logic wen,
                               input logic [31:0] ma, input logic [31:0] md, input logic [2:0] sz,
                               input logic we, input logic re);
        pl_t p;
        p.rd_addr  = ra;
        p.rd_data  = rdat;
        p.rd_wen   = wen;
        p.mem_addr = ma;
        p.mem_data = md;
        p.mem_size = sz;
        p.mem_we   = we;
        p.mem_re   = re;
        return p;
    endfunction

    function automatic pl_t tag(input int n);
        return mk(5'(n), 32'hA000_0000 + 32'(n), 1'b1, 32'h2000 + 32'(n * 4),
                  32'hC0DE_0000 + 32'(n), MEM_SIZE_W, 1'b0, 1'b1);
    endfunction

    function automatic pl_t dut_out();
        return mk(bus.rd_addr_o, bus.rd_data_o, bus.rd_wen_o, bus.mem_addr_o,
                  bus.mem_data_o, bus.mem_size_o, bus.mem_we_o, bus.mem_re_o);
    endfunction

    // Applies one cycle of stimulus; entered and left at posedge+1.
    task automatic drive(input logic v, input pl_t p, input logic ordy, input logic fl);
        bus.in_valid_i  = v;
        bus.rd_addr_i   = p.rd_addr;
        bus.rd_data_i   = p.rd_data;
        bus.rd_wen_i    = p.rd_wen;
        bus.mem_addr_i  = p.mem_addr;
        bus.mem_data_i  = p.mem_data;
        bus.mem_size_i  = p.mem_size;
        bus.mem_we_i    = p.mem_we;
        bus.mem_re_i    = p.mem_re;
        bus.out_ready_i = ordy;
        bus.flush_i     = fl;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: the issue side pushes every entry the model says is
    // accepted; the check side compares the presented payload to the queue head.
    always @(negedge clk) begin
        pl_t in_p;
        bit  in_acc;
        bit  out_acc;
        if (!rst_n) begin
            chk("reset_out_valid", 128'(bus.out_valid_o), 128'd0);
            chk("reset_in_ready", 128'(bus.in_ready_o), 128'd1);
            chk("reset_payload", 128'(dut_out()), 128'd0);
            exp_q.delete();
        end else begin
            chk("out_valid", 128'(bus.out_valid_o), 128'(exp_q.size() > 0));
            chk("in_ready", 128'(bus.in_ready_o), 128'(exp_q.size() < 2));
            if (exp_q.size() > 0)
                chk("payload", 128'(dut_out()), 128'(exp_q[0]));
            else
                chk("bubble_enables", 128'({bus.rd_wen_o, bus.mem_we_o, bus.mem_re_o}), 128'd0);

            in_p = mk(bus.rd_addr_i, bus.rd_data_i, bus.rd_wen_i, bus.mem_addr_i,
                      bus.mem_data_i, bus.mem_size_i, bus.mem_we_i, bus.mem_re_i);
            in_acc  = bus.in_valid_i && (exp_q.size() < 2);
            out_acc = bus.out_ready_i && (exp_q.size() > 0);
            if (bus.flush_i) begin
                exp_q.delete();
            end else begin
                if (out_acc) void'(exp_q.pop_front());
                if (in_acc) exp_q.push_back(in_p);
            end
        end
    end

    initial begin
        pl_t         idle;
        pl_t         rp;
        logic [127:0] r;
        idle = '0;
        rst_n = 1'b0;
        bus.in_valid_i = 1'b0; bus.flush_i = 1'b0; bus.out_ready_i = 1'b0;
        bus.rd_addr_i = '0; bus.rd_data_i = '0; bus.rd_wen_i = 1'b0;
        bus.mem_addr_i = '0; bus.mem_data_i = '0; bus.mem_size_i = '0;
        bus.mem_we_i = 1'b0; bus.mem_re_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, idle, 1'b1, 1'b0);

        // Single entry, one-cycle latency.
        drive(1'b1, mk(5'd5, 32'h1234_5678, 1'b1, 32'h0, 32'h0, MEM_SIZE_W, 1'b0, 1'b0), 1'b1, 1'b0);
        drive(1'b0, idle, 1'b1, 1'b0);
        drive(1'b0, idle, 1'b1, 1'b0);

        // Eight back-to-back entries at full throughput.
        for (int i = 1; i <= 8; i++) drive(1'b1, tag(i), 1'b1, 1'b0);
        drive(1'b0, idle, 1'b1, 1'b0);
        drive(1'b0, idle, 1'b1, 1'b0);

        // Back-pressure: third entry waits until the skid drains.
        drive(1'b1, tag(11), 1'b0, 1'b0);
        drive(1'b1, tag(12), 1'b0, 1'b0);
        drive(1'b1, tag(13), 1'b0, 1'b0);
        drive(1'b1, tag(13), 1'b0, 1'b0);
        drive(1'b1, tag(13), 1'b1, 1'b0);
        drive(1'b1, tag(13), 1'b1, 1'b0);
        drive(1'b0, idle, 1'b1, 1'b0);
        drive(1'b0, idle, 1'b1, 1'b0);

        // Flush in state TWO holding a store, with a same-cycle input.
        drive(1'b1, mk(5'd7, 32'h0, 1'b0, 32'h100, 32'hDEAD_BEEF, MEM_SIZE_W, 1'b1, 1'b0), 1'b0, 1'b0);
        drive(1'b1, tag(20), 1'b0, 1'b0);
        drive(1'b1, tag(21), 1'b0, 1'b1);
        drive(1'b0, idle, 1'b1, 1'b0);
        drive(1'b0, idle, 1'b1, 1'b0);

        // Asynchronous reset between edges while in state ONE.
        drive(1'b1, tag(30), 1'b0, 1'b0);
        bus.in_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_out_valid", 128'(bus.out_valid_o), 128'd0);
        chk("async_rst_in_ready", 128'(bus.in_ready_o), 128'd1);
        chk("async_rst_payload", 128'(dut_out()), 128'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) drive(1'b0, idle, 1'b1, 1'b0);
        drive(1'b1, tag(31), 1'b1, 1'b0);
        drive(1'b0, idle, 1'b1, 1'b0);
        drive(1'b0, idle, 1'b1, 1'b0);

        // Random valid/ready/flush against the queue model.
        for (int i = 0; i < 10000; i++) begin
            r  = {$urandom, $urandom, $urandom, $urandom};
            rp = r[$bits(pl_t)-1:0];
            drive($urandom_range(0, 3) != 0, rp, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 63) == 0);
        end
        repeat (3) drive(1'b0, idle, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
